seg7_bank: RTL and testbench



---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_font.sv | 13 +
 rtl/seg7_bank.sv | 175 +++++++++++++++++
 tb/tb_seg7_bank.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display bank: modes, controller states, font.
// Latency: none (package only).
// Backpressure: not applicable.
package seg7_pkg;

    localparam logic [1:0] MODE_BLANK = 2'd0;
    localparam logic [1:0] MODE_HEX   = 2'd1;
    localparam logic [1:0] MODE_LZ    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Active-high segments {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_font.sv
// Hex nibble to active-high 7-segment glyph decoder.
// Latency: combinational.
// Backpressure: none.
module seg7_font
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = FONT[nib];

endmodule

// File: rtl/seg7_bank.sv
// N-digit 7-segment controller: decodes one digit per cycle into staging, commits atomically, blinks per digit.
// Latency: outputs update DIGITS+1 cycles after an accepted write.
// Backpressure: ready is low while an update is in flight; we is ignored then (no queuing).
module seg7_bank
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 6,
    parameter int CLK_HZ     = 25000000,
    parameter int BLINK_HZ   = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  we,
    output logic                  ready,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [1:0]            mode,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [7*DIGITS-1:0]   hex_out,
    output logic [DIGITS-1:0]     dp_out
);

    localparam int IDXW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PERIOD = CLK_HZ / (2 * BLINK_HZ);
    localparam int CNTW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNTW-1:0] CNT_TC    = CNTW'(PERIOD - 1);
    localparam logic [6:0]      SEG_BLANK = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic            DP_BLANK  = (ACTIVE_LOW != 0);

    state_t                    state_q, state_d;
    logic [IDXW-1:0]           idx_q, idx_d;
    logic                      lz_q, lz_d;
    logic [4*DIGITS-1:0]       val_q, val_d;
    logic [DIGITS-1:0]         dpi_q, dpi_d;
    logic [1:0]                mode_q, mode_d;
    logic [DIGITS-1:0]         mask_q, mask_d;
    logic [DIGITS-1:0][6:0]    stg_q, stg_d;
    logic [DIGITS-1:0]         stg_dp_q, stg_dp_d;
    logic [DIGITS-1:0][6:0]    disp_q, disp_d;
    logic [DIGITS-1:0]         disp_dp_q, disp_dp_d;
    logic [DIGITS-1:0]         disp_mask_q, disp_mask_d;
    logic [CNTW-1:0]           cnt_q, cnt_d;
    logic                      phase_q, phase_d;

    logic [3:0]                cur_nib;
    logic [6:0]                font_seg;
    logic                      blank_dig;

    // Single shared decoder, fed by the digit currently being staged.
    assign cur_nib = val_q[{idx_q, 2'b00} +: 4];

    seg7_font u_font (
        .nib (cur_nib),
        .seg (font_seg)
    );

    assign ready = (state_q == ST_IDLE);

    // Controller: latch a write, stage digits from the top down, then commit all at once.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lz_d        = lz_q;
        val_d       = val_q;
        dpi_d       = dpi_q;
        mode_d      = mode_q;
        mask_d      = mask_q;
        stg_d       = stg_q;
        stg_dp_d    = stg_dp_q;
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        disp_mask_d = disp_mask_q;
        blank_dig   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (we) begin
                    val_d   = value;
                    dpi_d   = dp_in;
                    mode_d  = mode;
                    mask_d  = blink_mask;
                    idx_d   = IDXW'(DIGITS - 1);
                    lz_d    = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Digit 0 is never suppressed so an all-zero value still shows "0".
                blank_dig = (mode_q == MODE_BLANK) ||
                            ((mode_q == MODE_LZ) && lz_q && (cur_nib == 4'd0) && (idx_q != '0));
                stg_d[idx_q] = blank_dig ? SEG_BLANK
                                         : ((ACTIVE_LOW != 0) ? ~font_seg : font_seg);
                // A suppressed digit still keeps its decimal point.
                stg_dp_d[idx_q] = (mode_q == MODE_BLANK) ? DP_BLANK
                                                         : (dpi_q[idx_q] ^ DP_BLANK);
                if (cur_nib != 4'd0) begin
                    lz_d = 1'b0;
                end
                if (idx_q == '0) begin
                    state_d = ST_COMMIT;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            ST_COMMIT: begin
                disp_d      = stg_q;
                disp_dp_d   = stg_dp_q;
                disp_mask_d = mask_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Free-running blink timer; phase flips each time the counter wraps.
    always_comb begin
        cnt_d   = cnt_q + CNTW'(1);
        phase_d = phase_q;
        if (cnt_q == CNT_TC) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    // State, shadow, staging, display and timer registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            lz_q        <= 1'b1;
            val_q       <= '0;
            dpi_q       <= '0;
            mode_q      <= MODE_BLANK;
            mask_q      <= '0;
            stg_q       <= {DIGITS{SEG_BLANK}};
            stg_dp_q    <= {DIGITS{DP_BLANK}};
            disp_q      <= {DIGITS{SEG_BLANK}};
            disp_dp_q   <= {DIGITS{DP_BLANK}};
            disp_mask_q <= '0;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lz_q        <= lz_d;
            val_q       <= val_d;
            dpi_q       <= dpi_d;
            mode_q      <= mode_d;
            mask_q      <= mask_d;
            stg_q       <= stg_d;
            stg_dp_q    <= stg_dp_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            disp_mask_q <= disp_mask_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
        end
    end

    // Output stage: blank the blinking digits during the off phase.
    always_comb begin
        hex_out = '0;
        dp_out  = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (phase_q && disp_mask_q[k]) begin
                hex_out[7*k +: 7] = SEG_BLANK;
                dp_out[k]         = DP_BLANK;
            end else begin
                hex_out[7*k +: 7] = disp_q[k];
                dp_out[k]         = disp_dp_q[k];
            end
        end
    end

endmodule

// File: tb/tb_seg7_bank.sv
// Self-checking bench for seg7_bank (6 digits, active-low, 4-cycle blink phase).
// Latency: n/a.
// Backpressure: n/a.
module tb_seg7_bank;

    localparam int D = 6;

    localparam logic [6:0] FONT_TB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic            clock;
    logic            reset_n;
    logic            we;
    logic            ready;
    logic [4*D-1:0]  value;
    logic [D-1:0]    dp_in;
    logic [1:0]      mode;
    logic [D-1:0]    blink_mask;
    logic [7*D-1:0]  hex_out;
    logic [D-1:0]    dp_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Currently committed content according to the reference model.
    logic [4*D-1:0]  cur_v;
    logic [D-1:0]    cur_dp;
    logic [1:0]      cur_m;
    logic [D-1:0]    cur_bm;

    seg7_bank #(
        .DIGITS     (D),
        .CLK_HZ     (8),
        .BLINK_HZ   (1),
        .ACTIVE_LOW (1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .we         (we),
        .ready      (ready),
        .value      (value),
        .dp_in      (dp_in),
        .mode       (mode),
        .blink_mask (blink_mask),
        .hex_out    (hex_out),
        .dp_out     (dp_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Clock edges since reset release; blink phase is (edges / 4) mod 2.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: what the display should show for a committed write at a given blink phase.
    function automatic void model(input logic [4*D-1:0] v, input logic [D-1:0] dp,
                                  input logic [1:0] m, input logic [D-1:0] bm, input bit ph,
                                  output logic [7*D-1:0] hx, output logic [D-1:0] dx);
        int top = -1;
        for (int k = 0; k < D; k++) if (v[4*k +: 4] != 4'd0) top = k;
        for (int k = 0; k < D; k++) begin
            bit show = (m != 2'd0) && !((m == 2'd2) && (k > top) && (k != 0));
            logic [6:0] seg = show ? FONT_TB[v[4*k +: 4]] : 7'h00;
            bit dlit = (m != 2'd0) && dp[k];
            if (ph && bm[k]) begin
                seg  = 7'h00;
                dlit = 1'b0;
            end
            hx[7*k +: 7] = ~seg;
            dx[k]        = ~dlit;
        end
    endfunction

    task automatic check_outputs(input string tag);
        logic [7*D-1:0] hx;
        logic [D-1:0]   dx;
        model(cur_v, cur_dp, cur_m, cur_bm, ((cyc / 4) % 2) == 1, hx, dx);
        chk({tag, ".hex"}, 64'(hex_out), 64'(hx));
        chk({tag, ".dp"},  64'(dp_out),  64'(dx));
    endtask

    task automatic start_write(input logic [4*D-1:0] v, input logic [D-1:0] dp,
                               input logic [1:0] m, input logic [D-1:0] bm);
        @(negedge clock);
        value = v; dp_in = dp; mode = m; blink_mask = bm; we = 1'b1;
        @(negedge clock);
        we = 1'b0;
    endtask

    // Counts sampled cycles with ready low (bounded); optionally pokes a second write mid-decode.
    task automatic wait_ready(input bit poke, output int n);
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            if (poke && n == 2) begin
                we = 1'b1; value = 24'h123456; mode = 2'd1; dp_in = '1; blink_mask = '1;
            end else begin
                we = 1'b0;
            end
            @(negedge clock);
            n++;
        end
        we = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [4*D-1:0] v, input logic [D-1:0] dp,
                            input logic [1:0] m, input logic [D-1:0] bm, input bit poke);
        int n;
        start_write(v, dp, m, bm);
        wait_ready(poke, n);
        chk({tag, ".ready_low_cycles"}, 64'(n), 64'(D + 1));
        cur_v = v; cur_dp = dp; cur_m = m; cur_bm = bm;
        check_outputs(tag);
    endtask

    initial begin
        int n;
        logic [4*D-1:0] rv;
        logic [1:0]     rm;
        logic [D-1:0]   rdp, rbm;
        int             nz;

        reset_n = 1'b0; we = 1'b0; value = '0; dp_in = '0; mode = 2'd0; blink_mask = '0;
        cur_v = '0; cur_dp = '0; cur_m = 2'd0; cur_bm = '0;
        #12;
        chk("reset.hex",   64'(hex_out), 64'(42'h3FF_FFFF_FFFF));
        chk("reset.dp",    64'(dp_out),  64'(6'h3F));
        chk("reset.ready", 64'(ready),   64'(1));
        @(negedge clock);
        reset_n = 1'b1;

        // Plain hex with leading zeros shown.
        do_write("hexA5", 24'h0000A5, 6'h00, 2'd1, 6'h00, 1'b0);
        chk("hexA5.const", 64'(hex_out), 64'({7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12}));

        // Leading-zero suppression.
        do_write("lzA5", 24'h0000A5, 6'h00, 2'd2, 6'h00, 1'b0);
        chk("lzA5.const", 64'(hex_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12}));
        do_write("lz0", 24'h000000, 6'h24, 2'd2, 6'h00, 1'b0);
        chk("lz0.const", 64'(hex_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));

        // Blank mode and reserved mode.
        do_write("blank", 24'hFEDCBA, 6'h3F, 2'd0, 6'h00, 1'b0);
        do_write("mode3", 24'h987654, 6'h15, 2'd3, 6'h00, 1'b0);

        // A write during decode must be ignored: no overwrite, no queued second update.
        do_write("poke", 24'h0C0FFE, 6'h01, 2'd2, 6'h00, 1'b1);
        repeat (10) @(negedge clock);
        chk("poke.ready_idle", 64'(ready), 64'(1));
        check_outputs("poke.later");

        // Blink on digit 0 only; sample across several phases.
        do_write("blink", 24'h0000A5, 6'h03, 2'd1, 6'h01, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check_outputs("blink.step");
        end

        // Randomized writes against the model.
        for (int i = 0; i < 8; i++) begin
            rv  = 24'($urandom);
            nz  = $urandom_range(0, D);
            for (int k = D - nz; k < D; k++) rv[4*k +: 4] = 4'd0;
            rm  = 2'($urandom_range(0, 3));
            rdp = 6'($urandom);
            rbm = 6'($urandom);
            do_write("rand", rv, rdp, rm, rbm, 1'b0);
            repeat (3) @(negedge clock);
            check_outputs("rand.later");
        end

        // Asynchronous reset in the middle of decode.
        start_write(24'h123456, 6'h2A, 2'd1, 6'h00);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midrst.hex",   64'(hex_out), 64'(42'h3FF_FFFF_FFFF));
        chk("midrst.dp",    64'(dp_out),  64'(6'h3F));
        chk("midrst.ready", 64'(ready),   64'(1));
        cur_v = '0; cur_dp = '0; cur_m = 2'd0; cur_bm = '0;
        @(negedge clock);
        reset_n = 1'b1;
        do_write("after_rst", 24'h00BEEF, 6'h10, 2'd2, 6'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
